// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter:
// serialiser states, register offsets and STATUS bit positions.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  // STATUS has a 4-bit count field; deeper FIFOs report 15 when fuller than that.
  function automatic logic [3:0] sat_count4(input int unsigned count);
    return (count > 15) ? 4'd15 : 4'(count);
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Processor memory-port bundle seen by the UART register window.
interface uart_tx_mmio_if;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel_o;

  modport master (output addr_i, we_i, data_i, input data_o, sel_o);
  modport slave  (input addr_i, we_i, data_i, output data_o, sel_o);
endinterface

// File: rtl/sync_fifo.sv
// Small first-word-fallthrough FIFO: pop_data always shows the oldest entry.
// A push while full is dropped; push and pop on one edge keep count unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a byte FIFO, STATUS reports it.
// Define UART_TX_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 217,
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset_i,
  uart_tx_mmio_if.slave bus,
  output logic          tx_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic             hit;
  logic [1:0]       offset;
  logic [1:0]       stb;
  logic [1:0]       stb_q_reg;
  logic [1:0]       fire;
  logic             push;
  logic             pop;
  logic             ovf_reg;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      status;
  logic [31:0]      rdata;

  state_t           state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             bit_end;

  logic unused_bits;
  assign unused_bits = ^{bus.addr_i[1:0], bus.data_i[31:8]};

  assign hit       = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus.addr_i[3:2];
  assign bus.sel_o = hit;

  // The bus holds we_i for several cycles per store, so each register acts on the rising strobe only.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stb
    assign stb[gi]  = bus.we_i & hit & (offset == 2'(gi));
    assign fire[gi] = stb[gi] & ~stb_q_reg[gi];
  end

  assign push = fire[REG_DATA];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      stb_q_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      stb_q_reg <= stb;
      if (push && fifo_full) begin
        ovf_reg <= 1'b1;
      end else if (fire[REG_STATUS] && bus.data_i[3]) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .srst      (reset_i),
    .push      (push),
    .push_data (bus.data_i[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status                       = '0;
    status[STAT_BUSY]            = (state_reg != IDLE);
    status[STAT_FULL]            = fifo_full;
    status[STAT_EMPTY]           = fifo_empty;
    status[STAT_OVF]             = ovf_reg;
    status[STAT_CNT_LSB +: 4]    = sat_count4(32'(fifo_count));
  end

  always_comb begin
    rdata = '0;
    if (hit && offset == REG_STATUS) begin
      rdata = status;
    end
  end

  assign bus.data_o = rdata;

  // Serialiser state register, together with the datapath it steers.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  assign bit_end = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));
  assign pop     = (state_reg == IDLE) & ~fifo_empty;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (!fifo_empty) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end && bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP:  if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_next is chosen from the upcoming state so tx_o changes exactly on bit boundaries.
  always_comb begin
    baud_next    = '0;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = 1'b1;
    if (state_reg != IDLE && !bit_end) begin
      baud_next = baud_reg + 1'b1;
    end
    if (pop) begin
      shift_next = fifo_data;
    end
    if (state_reg == IDLE) begin
      bit_idx_next = '0;
    end else if (state_reg == DATA && bit_end) begin
      bit_idx_next = bit_idx_reg + 3'd1;
    end
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = ^shift_reg;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_o = tx_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed plus randomized bench for uart_tx_mmio with a behavioural serial receiver.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hF000_0000;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic tx_o;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .BASE_ADDR    (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_i (reset_i),
    .bus     (bus),
    .tx_o    (tx_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         rx_en = 1'b0;
  logic       last_parity = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    @(posedge clk); #1;
    bus.addr_i = a;
    bus.we_i   = 1'b1;
    bus.data_i = d;
    repeat (hold) @(posedge clk);
    #1;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    bus.addr_i = a;
    bus.we_i   = 1'b0;
    #1;
    d = bus.data_o;
    s = bus.sel_o;
  endtask

  task automatic wait_rx(input int n, input int limit);
    int c = 0;
    while (rx_q.size() < n && c < limit) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("rx_count", rx_q.size(), n);
  endtask

  task automatic compare_rx(input string tag);
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      chk(tag, {24'h0, rx_q.pop_front()}, {24'h0, exp_q.pop_front()});
    end
    chk({tag, "_leftover"}, exp_q.size() + rx_q.size(), 0);
    exp_q.delete();
    rx_q.delete();
  endtask

  // Behavioural receiver: samples mid-bit after each detected start edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i && tx_o === 1'b0) begin
        bit         en;
        logic [7:0] b;
        logic       s, p, st;
        en = rx_en;
        p  = 1'b0;
        repeat (CPB/2) @(negedge clk);
        s = tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_o;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx_o;
`endif
        repeat (CPB) @(negedge clk);
        st = tx_o;
        if (en) begin
          chk("rx_start", s, 1'b0);
`ifdef UART_TX_PARITY_EN
          chk("rx_parity", p, ^b);
`endif
          chk("rx_stop", st, 1'b1);
          last_parity = p;
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, prev;
    logic        s;
    logic [10:0] frame;
    logic [7:0]  b;
    int          occ, lows, n;
    bit          ovf_m;

    bus.addr_i = 32'h0;
    bus.we_i   = 1'b0;
    bus.data_i = 32'h0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_o !== 1'b1) lows++;
      @(posedge clk); #1;
    end
    chk("idle_tx_high", lows, 0);
    bus_read(BASE + 4, d, s);
    chk("reset_status", d, 32'h4);
    chk("status_sel", s, 1'b1);

    // Single frame with we_i held two cycles
    rx_en = 1'b1;
    b = 8'hA5;
`ifdef UART_TX_PARITY_EN
    frame = {1'b1, ^b, b, 1'b0};
`else
    frame = {1'b0, 1'b1, b, 1'b0};
`endif
    @(posedge clk); #1;
    bus.addr_i = BASE; bus.we_i = 1'b1; bus.data_i = 32'h0000_00A5;
    @(posedge clk); #1;
    chk("a5_c1_idle", tx_o, 1'b1);
    @(posedge clk); #1;
    bus.we_i = 1'b0; bus.addr_i = 32'h0;
    for (int j = 0; j < FRAME_BITS * CPB; j++) begin
      chk($sformatf("a5_bit%0d", j / CPB), tx_o, frame[j / CPB]);
      if (j == 10) begin
        bus_read(BASE + 4, d, s);
        chk("a5_status_busy", d, 32'h5);
      end
      @(posedge clk); #1;
    end
    chk("a5_after_stop", tx_o, 1'b1);
    exp_q.push_back(8'hA5);
    repeat (FRAME_BITS * CPB * 2 + 10) @(posedge clk);
    #1;
    chk("a5_single_push", rx_q.size(), 1);
    compare_rx("a5_byte");

    // Burst of ten writes: one in flight plus DEPTH queued, the rest dropped
    occ = 0;
    ovf_m = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus_write(BASE, k, 2);
      if (occ < DEPTH + 1) begin
        exp_q.push_back(8'(k));
        occ++;
      end else begin
        ovf_m = 1'b1;
      end
      if (k >= 9) begin
        n = occ - 1;
        bus_read(BASE + 4, d, s);
        chk($sformatf("burst_status_w%0d", k), d,
            32'(1 | ((n == DEPTH) << 1) | ((n == 0) << 2) | (ovf_m << 3) | ((n > 15 ? 15 : n) << 4)));
      end
    end
    prev = d;
    bus_write(BASE + 4, 32'h8, 2);
    bus_read(BASE + 4, d, s);
    chk("ovf_clear", d, prev & ~32'h8);
    wait_rx(9, 9 * FRAME_BITS * CPB + 200);
    compare_rx("burst_byte");
    repeat (10) @(posedge clk);
    #1;
    bus_read(BASE + 4, d, s);
    chk("burst_drained_status", d, 32'h4);

    // Decode
    bus_read(BASE + 8, d, s);
    chk("off2_data", d, 32'h0);
    chk("off2_sel", s, 1'b1);
    bus_read(32'h0000_1000, d, s);
    chk("miss_data", d, 32'h0);
    chk("miss_sel", s, 1'b0);
    bus_read(BASE, d, s);
    chk("datareg_read", d, 32'h0);

    // Randomized bytes within FIFO capacity
    n = $urandom_range(4, 8);
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      bus_write(BASE, {24'h0, b}, $urandom_range(1, 3));
      exp_q.push_back(b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_rx(n, n * FRAME_BITS * CPB + 200);
    compare_rx("rand_byte");
    repeat (10) @(posedge clk);
    #1;
    bus_read(BASE + 4, d, s);
    chk("rand_status", d, 32'h4);

`ifdef UART_TX_PARITY_EN
    bus_write(BASE, 32'h07, 2);
    exp_q.push_back(8'h07);
    wait_rx(1, FRAME_BITS * CPB + 100);
    chk("parity_07", last_parity, 1'b1);
    compare_rx("par_byte");
    repeat (10) @(posedge clk);
`endif

    // Reset in the middle of a frame with more bytes queued
    rx_en = 1'b0;
    bus_write(BASE, 32'h3C, 2);
    bus_write(BASE, 32'h5A, 2);
    bus_write(BASE, 32'h66, 2);
    repeat (6) @(posedge clk);
    #1;
    bus_read(BASE + 4, d, s);
    chk("pre_reset_busy", d[0], 1'b1);
    @(posedge clk); #1 reset_i = 1'b1;
    @(posedge clk); #1 reset_i = 1'b0;
    chk("reset_tx_next", tx_o, 1'b1);
    bus_read(BASE + 4, d, s);
    chk("reset_status_mid", d, 32'h4);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx_o !== 1'b1) lows++;
    end
    chk("no_frames_after_reset", lows, 0);
    rx_en = 1'b1;
    chk("no_rx_after_reset", rx_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
